smd_multipad_encoder: RTL and testbench

//  Parametrised Genesis/Mega Drive pad encoder serving NUM_PADS independent controller ports.
//  - Each channel synchronises its console select line (TH, pin 7).
//  - Each channel counts select edges into a 3-bit phase and drives the six data pins for that phase.
//  - Each channel returns to phase 0 after a select-idle timeout.
//  - A per-channel mode input selects 3-button or 6-button protocol.
//  - Sits between the debounced button front-end and the DB9 output drivers.

---
 rtl/smd_multipad_encoder.sv | 137 +++++++++++++
 tb/tb_smd_multipad_encoder.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/smd_multipad_encoder.sv
// Genesis/Mega Drive multi-port pad encoder: select sync, phase counting, idle timeout, pin mux.
// Optional autofire on the six action buttons when SMD_TURBO_EN is defined.
module smd_multipad_encoder #(
   parameter int NUM_PADS    = 1,
   parameter int CLK_FREQ    = 20000000,
   parameter int TIMEOUT_US  = 1500,
   parameter int SYNC_STAGES = 2,
   parameter int TURBO_HZ    = 15
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_PADS-1:0]     sel,
   input  logic [12*NUM_PADS-1:0]  btn,
   input  logic [NUM_PADS-1:0]     six_btn,
`ifdef SMD_TURBO_EN
   input  logic [6*NUM_PADS-1:0]   turbo_mask,
`endif
   output logic [6*NUM_PADS-1:0]   p,
   output logic [3*NUM_PADS-1:0]   phase_dbg
);

   localparam int TO_CYC = CLK_FREQ / 1000000 * TIMEOUT_US;
   localparam int CW     = $clog2(TO_CYC + 1);
   localparam logic [CW-1:0] TO_LOAD = CW'(TO_CYC);

   localparam logic [2:0] PH_0 = 3'd0;
   localparam logic [2:0] PH_3 = 3'd3;
   localparam logic [2:0] PH_4 = 3'd4;
   localparam logic [2:0] PH_5 = 3'd5;

`ifdef SMD_TURBO_EN
   localparam int TURBO_DIV = CLK_FREQ / (2 * TURBO_HZ);
   localparam int TW        = $clog2(TURBO_DIV + 1);

   logic [TW-1:0] turbo_cnt;
   logic          turbo_ph;

   // One divider shared by all pads so autofire stays in step across ports.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         turbo_cnt <= '0;
         turbo_ph  <= 1'b0;
      end else if (turbo_cnt == TW'(TURBO_DIV - 1)) begin
         turbo_cnt <= '0;
         turbo_ph  <= ~turbo_ph;
      end else begin
         turbo_cnt <= turbo_cnt + TW'(1);
      end
   end
`endif

   for (genvar i = 0; i < NUM_PADS; i++) begin : g_pad
      logic [SYNC_STAGES-1:0] sync;
      logic                   s;
      logic                   last_sel;
      logic                   mode_q;
      logic                   edge_det;
      logic [2:0]             phase;
      logic [2:0]             phase_n;
      logic [CW-1:0]          cnt;
      logic [CW-1:0]          cnt_n;
      logic [11:0]            b;
      logic [5:0]             p_n;
      logic [5:0]             p_q;

      assign s        = sync[SYNC_STAGES-1];
      assign edge_det = (s != last_sel);

      always_comb begin
         b = btn[12*i +: 12];
`ifdef SMD_TURBO_EN
         b[4]  = b[4]  | (turbo_mask[6*i+0] & turbo_ph);
         b[5]  = b[5]  | (turbo_mask[6*i+1] & turbo_ph);
         b[6]  = b[6]  | (turbo_mask[6*i+2] & turbo_ph);
         b[8]  = b[8]  | (turbo_mask[6*i+3] & turbo_ph);
         b[9]  = b[9]  | (turbo_mask[6*i+4] & turbo_ph);
         b[10] = b[10] | (turbo_mask[6*i+5] & turbo_ph);
`endif
      end

      // An edge beats a same-cycle expiry; a mode change or 3-button mode pins phase to 0.
      always_comb begin
         phase_n = phase;
         cnt_n   = cnt;
         if (edge_det) begin
            phase_n = phase + 3'd1;
            cnt_n   = TO_LOAD;
         end else if (cnt == '0) begin
            phase_n = PH_0;
            cnt_n   = TO_LOAD;
         end else begin
            cnt_n = cnt - CW'(1);
         end
         if (!six_btn[i] || (six_btn[i] != mode_q))
            phase_n = PH_0;
      end

      // b = {md,z,y,x,st,c,b,a,rg,lf,dw,up}; pins ordered {1,2,3,4,6,9}.
      always_comb begin
         p_n = 6'h3F;
         if (!s) begin
            if (phase_n == PH_5)
               p_n = {4'b1111, b[4], b[7]};
            else if ((phase_n == PH_3) || (phase_n == PH_4))
               p_n = {4'b0000, b[4], b[7]};
            else
               p_n = {b[0], b[1], 2'b00, b[4], b[7]};
         end else if ((phase_n == PH_4) || (phase_n == PH_5)) begin
            p_n = {b[10], b[9], b[8], b[11], 2'b11};
         end else begin
            p_n = {b[0], b[1], b[2], b[3], b[5], b[6]};
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            sync     <= '1;
            last_sel <= 1'b1;
            mode_q   <= 1'b0;
            phase    <= PH_0;
            cnt      <= TO_LOAD;
            p_q      <= 6'h3F;
         end else begin
            sync     <= {sync[SYNC_STAGES-2:0], sel[i]};
            last_sel <= s;
            mode_q   <= six_btn[i];
            phase    <= phase_n;
            cnt      <= cnt_n;
            p_q      <= p_n;
         end
      end

      assign p[6*i +: 6]         = p_q;
      assign phase_dbg[3*i +: 3] = phase;
   end

endmodule

// File: tb/tb_smd_multipad_encoder.sv
// Bench for smd_multipad_encoder: hand-derived vector table, timing corner sequences,
// and randomized select/button traffic checked every cycle against a reference model.
`timescale 1ns/1ps
module tb_smd_multipad_encoder;

   localparam int NP      = 2;
   localparam int CLK_F   = 1000000;
   localparam int TO_US   = 20;
   localparam int SS      = 2;
   localparam int TO_CYC  = CLK_F / 1000000 * TO_US;

   logic            clk;
   logic            rst_n;
   logic [NP-1:0]   sel;
   logic [12*NP-1:0] btn;
   logic [NP-1:0]   six_btn;
   logic [6*NP-1:0] p;
   logic [3*NP-1:0] phase_dbg;
`ifdef SMD_TURBO_EN
   logic [6*NP-1:0] turbo_mask;
`endif

   int total = 0;
   int bad   = 0;

   smd_multipad_encoder #(
      .NUM_PADS(NP), .CLK_FREQ(CLK_F), .TIMEOUT_US(TO_US), .SYNC_STAGES(SS), .TURBO_HZ(15)
   ) dut (
      .clk(clk), .rst_n(rst_n), .sel(sel), .btn(btn), .six_btn(six_btn),
`ifdef SMD_TURBO_EN
      .turbo_mask(turbo_mask),
`endif
      .p(p), .phase_dbg(phase_dbg)
   );

   // clock / watchdog
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // reference model state
   int   m_ph   [NP];
   int   m_idle [NP];
   bit   m_last [NP];
   bit   m_mode [NP];
   bit   m_selq [NP][$];
   logic [5:0] exp_p [NP];

   function automatic logic [5:0] ref_map(int ph, bit s, logic [11:0] bv);
      logic up, dw, lf, rg, a, bb, c, st, x, y, z, md;
      {md, z, y, x, st, c, bb, a, rg, lf, dw, up} = bv;
      if (s) begin
         if (ph == 4 || ph == 5) return {z, y, x, md, 1'b1, 1'b1};
         return {up, dw, lf, rg, bb, c};
      end
      if (ph == 5) return {4'hF, a, st};
      if (ph == 3 || ph == 4) return {4'h0, a, st};
      return {up, dw, 2'b00, a, st};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NP; i++) begin
         m_ph[i]   = 0;
         m_idle[i] = 0;
         m_last[i] = 1'b1;
         m_mode[i] = 1'b0;
         m_selq[i].delete();
         for (int k = 0; k < SS; k++) m_selq[i].push_back(1'b1);
         exp_p[i] = 6'h3F;
      end
   endtask

   task automatic model_clock();
      for (int i = 0; i < NP; i++) begin
         bit s;
         bit ev;
         s  = m_selq[i][0];
         ev = (s != m_last[i]);
         if (ev) begin
            m_ph[i]   = (m_ph[i] + 1) % 8;
            m_idle[i] = 0;
         end else if (m_idle[i] == TO_CYC) begin
            m_ph[i]   = 0;
            m_idle[i] = 0;
         end else begin
            m_idle[i]++;
         end
         if (!six_btn[i] || (six_btn[i] != m_mode[i])) m_ph[i] = 0;
         exp_p[i]  = ref_map(m_ph[i], s, btn[12*i +: 12]);
         m_last[i] = s;
         m_mode[i] = six_btn[i];
         m_selq[i].push_back(sel[i]);
         void'(m_selq[i].pop_front());
      end
   endtask

   // scoreboard
   task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
      end
   endtask

   task automatic check_model();
      for (int i = 0; i < NP; i++) begin
         chk($sformatf("model_p%0d", i), 32'(p[6*i +: 6]), 32'(exp_p[i]));
         chk($sformatf("model_phase%0d", i), 32'(phase_dbg[3*i +: 3]), 32'(m_ph[i]));
      end
   endtask

   task automatic tick(int n = 1);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         model_clock();
         @(negedge clk);
         check_model();
      end
   endtask

   // driver tasks (always entered at a negedge or before the clock starts)
   task automatic do_reset();
      rst_n = 1'b0;
      sel   = '1;
      model_reset();
      #1;
      chk("reset_p", 32'(p), 32'({(6*NP){1'b1}}));
      chk("reset_phase", 32'(phase_dbg), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic toggle0(int gap);
      sel[0] = ~sel[0];
      tick(gap);
   endtask

   typedef struct {
      int          n_edges;
      bit          six;
      logic [11:0] b;
      logic [5:0]  exp;
   } vec_t;

   vec_t vecs[16];

   initial begin
      rst_n   = 1'b1;
      sel     = '1;
      btn     = '1;
      six_btn = '0;
`ifdef SMD_TURBO_EN
      turbo_mask = '0;
`endif
      model_reset();

      vecs[0]  = '{0, 1'b1, 12'h6FF, 6'h3F};
      vecs[1]  = '{1, 1'b1, 12'h6FF, 6'h33};
      vecs[2]  = '{3, 1'b1, 12'h6FF, 6'h03};
      vecs[3]  = '{4, 1'b1, 12'h6FF, 6'h33};
      vecs[4]  = '{5, 1'b1, 12'h6FF, 6'h3F};
      vecs[5]  = '{8, 1'b1, 12'h6FF, 6'h3F};
      vecs[6]  = '{1, 1'b0, 12'hFEE, 6'h11};
      vecs[7]  = '{2, 1'b0, 12'hFEE, 6'h1F};
      vecs[8]  = '{3, 1'b1, 12'hFEE, 6'h01};
      vecs[9]  = '{5, 1'b1, 12'hFEE, 6'h3D};
      vecs[10] = '{4, 1'b1, 12'hB7F, 6'h1F};
      vecs[11] = '{6, 1'b1, 12'hB7F, 6'h3F};
      vecs[12] = '{7, 1'b1, 12'hB7F, 6'h32};
      vecs[13] = '{5, 1'b1, 12'hB7F, 6'h3E};
      vecs[14] = '{2, 1'b1, 12'hFBB, 6'h36};
      vecs[15] = '{0, 1'b1, 12'hFBB, 6'h36};

      #2;
      // table: pad0 driven through n edges, pad1 idle in six-button mode
      for (int v = 0; v < 16; v++) begin
         btn     = '1;
         six_btn = {1'b1, vecs[v].six};
         do_reset();
         btn[11:0] = vecs[v].b;
         tick(2);
         for (int e = 0; e < vecs[v].n_edges; e++) toggle0(4);
         tick(3);
         chk($sformatf("vec%0d_p0", v), 32'(p[5:0]), 32'(vecs[v].exp));
         chk($sformatf("vec%0d_p1_idle", v), 32'(p[11:6]), 32'h3F);
         chk($sformatf("vec%0d_ph1_idle", v), 32'(phase_dbg[5:3]), 32'd0);
      end

      // timeout: 3 edges then select held past the idle limit
      btn = '1; btn[11:0] = 12'h6FF; six_btn = '1;
      do_reset();
      tick(2);
      for (int e = 0; e < 3; e++) toggle0(4);
      chk("timeout_before_p", 32'(p[5:0]), 32'h03);
      chk("timeout_before_ph", 32'(phase_dbg[2:0]), 32'd3);
      tick(TO_CYC + 2);
      chk("timeout_after_ph", 32'(phase_dbg[2:0]), 32'd0);
      chk("timeout_after_p", 32'(p[5:0]), 32'h33);

      // edge lands on the exact expiry cycle: edge wins
      do_reset();
      tick(2);
      toggle0(3);
      chk("sim_first_ph", 32'(phase_dbg[2:0]), 32'd1);
      tick(TO_CYC - 2);
      toggle0(3);
      chk("sim_edge_wins_ph", 32'(phase_dbg[2:0]), 32'd2);

      // edge one cycle after expiry: phase restarts from 0
      do_reset();
      tick(2);
      toggle0(3);
      tick(TO_CYC - 1);
      toggle0(3);
      chk("late_edge_ph", 32'(phase_dbg[2:0]), 32'd1);

      // mode change mid-sequence forces phase 0
      do_reset();
      tick(2);
      for (int e = 0; e < 3; e++) toggle0(4);
      six_btn[0] = 1'b0;
      tick(1);
      six_btn[0] = 1'b1;
      tick(1);
      chk("mode_change_ph", 32'(phase_dbg[2:0]), 32'd0);

      // asynchronous reset in the middle of a sequence
      for (int e = 0; e < 4; e++) toggle0(4);
      do_reset();
      tick(2);

      // randomized traffic on both pads against the model
      for (int n = 0; n < 300; n++) begin
         int pd;
         pd  = $urandom_range(0, NP - 1);
         btn = 24'($urandom());
         if ($urandom_range(0, 9) == 0) six_btn[pd] = ~six_btn[pd];
         if ($urandom_range(0, 3) != 0) sel[pd] = ~sel[pd];
         tick($urandom_range(1, TO_CYC + 4));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
